// File: rtl/tri_ramp_generator.sv
// Phase-accumulator waveform generator: triangle, saw up, saw down or square.
// Optional amplitude-scaling stage when TRI_GEN_AMPLITUDE_EN is defined.
module tri_ramp_generator #(
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [1:0]         mode_req,
  input  logic [DATA_W-1:0]  amp,
  output logic [DATA_W-1:0]  wave_out,
  output logic               out_valid,
  output logic               sync_out
);

  typedef enum logic [1:0] {
    MODE_TRI    = 2'b00,
    MODE_SAW_UP = 2'b01,
    MODE_SAW_DN = 2'b10,
    MODE_SQUARE = 2'b11
  } mode_t;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   acc_sum;
  logic               wrap;
  logic               period_start;
  mode_t              mode_q;

  logic [DATA_W-1:0]  s0_phase;
  mode_t              s0_mode;
  logic               s0_sync;
  logic               s0_valid;

  logic [DATA_W-1:0]  shape;
  logic [DATA_W-1:0]  s1_wave;
  logic               s1_sync;
  logic               s1_valid;

  assign acc_sum = {1'b0, acc} + {1'b0, tuning_word};
  assign wrap    = phase_clr | (enable & acc_sum[PHASE_W]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (phase_clr) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc_sum[PHASE_W-1:0];
    end
  end

  // Mode only changes at a period boundary; the flag marks that the next
  // sampled phase is the first of a new period and must carry sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_TRI;
      period_start <= 1'b0;
    end else if (wrap) begin
      mode_q       <= mode_t'(mode_req);
      period_start <= 1'b1;
    end else if (enable) begin
      period_start <= 1'b0;
    end
  end

  // Stage 0 captures the phase before this cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_phase <= '0;
      s0_mode  <= MODE_TRI;
      s0_sync  <= 1'b0;
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= enable;
      if (enable) begin
        s0_phase <= acc[PHASE_W-1 -: DATA_W];
        s0_mode  <= mode_q;
        s0_sync  <= period_start;
      end
    end
  end

  // NOTE: assign a default before the case so no path leaves the output
  // unassigned, which would infer a latch.
  always_comb begin
    shape = '0;
    case (s0_mode)
      MODE_TRI:    shape = s0_phase[DATA_W-1] ? {~s0_phase[DATA_W-2:0], 1'b1}
                                              : { s0_phase[DATA_W-2:0], 1'b0};
      MODE_SAW_UP: shape = s0_phase;
      MODE_SAW_DN: shape = ~s0_phase;
      MODE_SQUARE: shape = {DATA_W{s0_phase[DATA_W-1]}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_wave  <= '0;
      s1_sync  <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      s1_sync  <= s0_valid & s0_sync;
      if (s0_valid) begin
        s1_wave <= shape;
      end
    end
  end

`ifdef TRI_GEN_AMPLITUDE_EN
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   s2_wave;
  logic                s2_sync;
  logic                s2_valid;

  assign product = {{DATA_W{1'b0}}, s1_wave} * {{DATA_W{1'b0}}, amp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_wave  <= '0;
      s2_sync  <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_sync  <= s1_sync;
      if (s1_valid) begin
        s2_wave <= product[2*DATA_W-1:DATA_W];
      end
    end
  end

  assign wave_out  = s2_wave;
  assign out_valid = s2_valid;
  assign sync_out  = s2_sync;
`else
  logic unused_amp;
  assign unused_amp = ^amp;

  assign wave_out  = s1_wave;
  assign out_valid = s1_valid;
  assign sync_out  = s1_sync;
`endif

endmodule

// File: tb/tb_tri_ramp_generator.sv
// Self-checking bench for tri_ramp_generator: arithmetic reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_tri_ramp_generator;

  localparam int DATA_W  = 12;
  localparam int PHASE_W = 24;
  localparam int N       = 1 << DATA_W;
  localparam int HALF    = N / 2;
`ifdef TRI_GEN_AMPLITUDE_EN
  localparam int LAT        = 3;
  localparam int EXP_SECOND = 1;     // (2*2048)>>12
  localparam int EXP_PEAK   = 2047;  // (4095*2048)>>12
  localparam int EXP_1000   = 500;
`else
  localparam int LAT        = 2;
  localparam int EXP_SECOND = 2;
  localparam int EXP_PEAK   = 4095;
  localparam int EXP_1000   = 1000;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               phase_clr;
  logic [PHASE_W-1:0] tuning_word;
  logic [1:0]         mode_req;
  logic [DATA_W-1:0]  amp;
  logic [DATA_W-1:0]  wave_out;
  logic               out_valid;
  logic               sync_out;

  tri_ramp_generator #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .phase_clr(phase_clr),
    .tuning_word(tuning_word), .mode_req(mode_req), .amp(amp),
    .wave_out(wave_out), .out_valid(out_valid), .sync_out(sync_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain phase counter, the shapes as arithmetic on p,
  // and a LAT-deep delay line of (valid, sample, sync).
  longint m_acc;
  int     m_mode;
  bit     m_pend;
  bit     pv_v [LAT];
  int     pv_w [LAT];
  bit     pv_s [LAT];
  int     exp_wave;
  bit     exp_valid;
  bit     exp_sync;

  function automatic int shape_of(input int p, input int mode);
    case (mode)
      0:       return (p < HALF) ? 2 * p : 2 * (N - 1 - p) + 1;
      1:       return p;
      2:       return N - 1 - p;
      default: return (p >= HALF) ? N - 1 : 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int p;
    bit wrap;
    if (!rst_n) begin
      m_acc = 0; m_mode = 0; m_pend = 0;
      for (int i = 0; i < LAT; i++) begin pv_v[i] = 0; pv_w[i] = 0; pv_s[i] = 0; end
      exp_wave = 0; exp_valid = 0; exp_sync = 0;
    end else begin
      p = int'(m_acc >> (PHASE_W - DATA_W));
      for (int i = LAT - 1; i > 0; i--) begin
        pv_v[i] = pv_v[i-1]; pv_w[i] = pv_w[i-1]; pv_s[i] = pv_s[i-1];
      end
`ifdef TRI_GEN_AMPLITUDE_EN
      if (pv_v[LAT-1]) pv_w[LAT-1] = (pv_w[LAT-1] * int'(amp)) >> DATA_W;
`endif
      pv_v[0] = enable;
      pv_w[0] = shape_of(p, m_mode);
      pv_s[0] = m_pend;
      wrap = phase_clr || (enable && (m_acc + longint'(tuning_word)) >= (64'd1 << PHASE_W));
      if (phase_clr)   m_acc = 0;
      else if (enable) m_acc = (m_acc + longint'(tuning_word)) % (64'd1 << PHASE_W);
      if (wrap) begin
        m_mode = int'(mode_req);
        m_pend = 1;
      end else if (enable) begin
        m_pend = 0;
      end
      exp_valid = pv_v[LAT-1];
      if (exp_valid) exp_wave = pv_w[LAT-1];
      exp_sync = pv_v[LAT-1] && pv_s[LAT-1];
    end
  end

  always @(posedge clk) begin
    #1;
    if (check_en) begin
      check("cyc_wave_out", int'(wave_out), exp_wave);
      check("cyc_out_valid", int'(out_valid), int'(exp_valid));
      check("cyc_sync_out", int'(sync_out), int'(exp_sync));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    int cnt, peak, prev, zeros, syncs, sync_wave;

    rst_n = 1'b1; enable = 1'b0; phase_clr = 1'b0; tuning_word = 24'd4096;
    mode_req = 2'b00; amp = 12'd2048;
    #2 rst_n = 1'b0;
    #1;
    check("reset_wave_out", int'(wave_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sync_out", int'(sync_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1;

    // Triangle period: 0,2,...,4094,4095,...,1 with sync on sample 0.
    @(negedge clk); phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0; enable = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (out_valid && sync_out) found = 1;
    end
    check("tri_first_sync_seen", int'(found), 1);
    check("tri_first_sample", int'(wave_out), 0);
    tick();
    check("tri_second_sample", int'(wave_out), EXP_SECOND);
    cnt = 2; peak = int'(wave_out); found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      tick();
      if (out_valid) begin
        if (sync_out) found = 1;
        else begin
          cnt++;
          if (int'(wave_out) > peak) peak = int'(wave_out);
        end
      end
    end
    check("tri_period_wrap_seen", int'(found), 1);
    check("tri_period_samples", cnt, 4096);
    check("tri_peak", peak, EXP_PEAK);
    check("tri_wrap_sample", int'(wave_out), 0);

    // Saw up, then request saw down mid-period at p=1000.
    @(negedge clk); mode_req = 2'b01; phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (out_valid && sync_out) found = 1;
    end
    found = 0;
    for (int i = 0; i < 1100 && !found; i++) begin
      tick();
      if (out_valid && int'(wave_out) == EXP_1000) found = 1;
    end
    check("saw_reached_1000", int'(found), 1);
    @(negedge clk); mode_req = 2'b10;
    found = 0; prev = -1;
    for (int i = 0; i < 5000 && !found; i++) begin
      tick();
      if (out_valid) begin
        if (sync_out) found = 1;
        else prev = int'(wave_out);
      end
    end
    check("saw_switch_seen", int'(found), 1);
    check("saw_last_up", prev, EXP_PEAK);
    check("saw_first_down", int'(wave_out), EXP_PEAK);

    // Enable pattern 1,0,0,1: exactly two empty output cycles.
    zeros = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      enable = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      tick();
      if (!out_valid) zeros++;
    end
    check("gap_invalid_cycles", zeros, 2);

    // Zero tuning word: constant output, no sync.
    @(negedge clk); tuning_word = '0;
    syncs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sync_out) syncs++;
    end
    check("tw0_sync_count", syncs, 0);
    check("tw0_out_valid", int'(out_valid), 1);

    // phase_clr coinciding with a carry at p=3000: one sync, next sample 0.
    @(negedge clk); tuning_word = 24'd4096; mode_req = 2'b00;
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if ((m_acc >> (PHASE_W - DATA_W)) == 3000) found = 1;
    end
    check("clr_reached_3000", int'(found), 1);
    tuning_word = 24'hFFFFFF; phase_clr = 1'b1;
    @(negedge clk); tuning_word = 24'd4096; phase_clr = 1'b0;
    syncs = 0; sync_wave = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sync_out) begin syncs++; sync_wave = int'(wave_out); end
    end
    check("clr_carry_sync_count", syncs, 1);
    check("clr_carry_sample", sync_wave, 0);

    // Zero amplitude segment (ignored in the unscaled build).
    @(negedge clk); amp = '0;
    repeat (30) @(negedge clk);
    amp = 12'd2048; mode_req = 2'b01;

    // Asynchronous reset mid-period.
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("areset_wave_out", int'(wave_out), 0);
    check("areset_out_valid", int'(out_valid), 0);
    check("areset_sync_out", int'(sync_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    found = 0; cnt = -1;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (out_valid) begin found = 1; cnt = i; end
    end
    check("areset_latency", cnt, LAT - 1);
    check("areset_first_sample", int'(wave_out), 0);
    tick();
    check("areset_triangle_mode", int'(wave_out), EXP_SECOND);

    repeat (4) tick();
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
